// File: rtl/rca_multicycle.sv
// rca_multicycle: multi-cycle ripple-carry adder/subtractor.
//
// One CHUNK-bit ripple-carry slice (a chain of full-adder cells) is reused over
// N = WIDTH/CHUNK cycles, least-significant chunk first, with the carry held in
// a register between cycles. Valid/ready handshakes on both the operand and the
// result side; one operation in flight at a time.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, aborts any operation in flight
//   in_valid   operands and mode valid
//   in_ready   unit can accept an operation (IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in, add only
//   sub        0: a+b+cin, 1: a+~b+1 (cin ignored)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1 (for sub, 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       sum == 0
module rca_multicycle #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtract
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  // Ripple slice over the chunk selected by the counter.
  int unsigned      base;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] result;
  logic             last;

  always_comb begin
    logic c;
    base      = 32'(cnt_q) * CHUNK;
    a_sh      = a_q >> base;
    b_sh      = b_q >> base;
    slice_sum = '0;
    c         = carry_q;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      // Full-adder cell.
      slice_sum[i] = a_sh[i] ^ b_sh[i] ^ c;
      c            = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
    end
    slice_cout           = c;
    result               = sum_q;
    result[base +: CHUNK] = slice_sum;
    last                 = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            // Subtract is a + ~b + 1: the +1 rides in on the carry.
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          sum_q   <= result;
          carry_q <= slice_cout;
          if (last) begin
            cout_q  <= slice_cout;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
            zero_q  <= (result == '0);
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_rca_multicycle.sv
// Self-checking bench for rca_multicycle: table-driven add/sub vectors on the
// WIDTH=16/CHUNK=4 instance, plus directed backpressure, mid-operation reset
// and latency sequences across CHUNK=4, 16 and 1 instances.
module tb_rca_multicycle;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_ready;

  logic         in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] sum;
  logic         in_ready16, out_valid16, cout16, ovf16, zero16;
  logic [W-1:0] sum16;
  logic         in_ready1, out_valid1, cout1, ovf1, zero1;
  logic [W-1:0] sum1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rca_multicycle #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  rca_multicycle #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  rca_multicycle #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
    .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operation for a single accept edge; returns just after that edge.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vcin, input logic vsub);
    @(negedge clk);
    a        = va;
    b        = vb;
    cin      = vcin;
    sub      = vsub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid of the CHUNK=4 instance; 0 on timeout.
  task automatic wait_done(output int cyc);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    cyc = out_valid ? n : 0;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, lat4, lat16, lat1;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table on the CHUNK=4 instance.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      check($sformatf("v%0d in_ready busy", i), 32'(in_ready), 32'd0);
      wait_done(lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("v%0d cout", i), 32'(cout), 32'(vecs[i].cout));
      check($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].zero));
      handshake();
      check($sformatf("v%0d idle after handshake", i), {31'd0, in_ready & ~out_valid}, 32'd1);
    end

    // Backpressure: result held, new operands ignored while DONE.
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    wait_done(lat);
    check("bp latency", 32'(lat), 32'd4);
    @(negedge clk);
    a        = 16'hAAAA;
    b        = 16'h5555;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d sum held", k), 32'(sum), 32'h2233);
      check($sformatf("bp%0d valid/ready", k), {30'd0, out_valid, in_ready}, 32'b10);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake();
    check("bp in_ready after release", 32'(in_ready), 32'd1);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done(lat);
    check("bp next op sum", 32'(sum), 32'hFFFE);
    handshake();

    // Reset during the second BUSY cycle aborts the operation.
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort sum", 32'(sum), 32'd0);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    check("abort no result", 32'(lat), 32'd0);

    // Same add on all three slice widths, started together after a clean reset.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    lat4  = 0;
    lat16 = 0;
    lat1  = 0;
    for (int c = 1; c <= 40 && (lat4 == 0 || lat16 == 0 || lat1 == 0); c++) begin
      @(posedge clk);
      #1;
      if (out_valid && lat4 == 0) lat4 = c;
      if (out_valid16 && lat16 == 0) lat16 = c;
      if (out_valid1 && lat1 == 0) lat1 = c;
    end
    check("chunk4 latency", 32'(lat4), 32'd4);
    check("chunk16 latency", 32'(lat16), 32'd1);
    check("chunk1 latency", 32'(lat1), 32'd16);
    check("chunk4 sum", 32'(sum), 32'h2233);
    check("chunk16 sum", 32'(sum16), 32'h2233);
    check("chunk1 sum", 32'(sum1), 32'h2233);
    check("chunk16 flags", {29'd0, cout16, ovf16, zero16}, 32'd0);
    check("chunk1 flags", {29'd0, cout1, ovf1, zero1}, 32'd0);
    handshake();
    check("chunk16 idle", 32'(in_ready16), 32'd1);
    check("chunk1 idle", 32'(in_ready1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
